// File: rtl/spart_pkg.sv
// rtl/spart_pkg.sv - shared constants and types for the SPART bus responder
//
// Purpose: register address map, status bit positions and the TX holding
//          register state type used by spart_bus_responder and its FIFO.
// Ports:   none (package).

package spart_pkg;

   // Register select values on ioaddr
   localparam logic [1:0] ADDR_DATA   = 2'b00;
   localparam logic [1:0] ADDR_STATUS = 2'b01;
   localparam logic [1:0] ADDR_DB_LO  = 2'b10;
   localparam logic [1:0] ADDR_DB_HI  = 2'b11;

   // Bit positions inside the status byte {5'b0, overrun, tbr, rda}
   localparam int STAT_RDA = 0;
   localparam int STAT_TBR = 1;
   localparam int STAT_OVR = 2;

   // TX holding register occupancy
   typedef enum logic {
      TX_EMPTY = 1'b0,
      TX_FULL  = 1'b1
   } tx_state_e;

endpackage

// File: rtl/spart_rx_fifo.sv
// rtl/spart_rx_fifo.sv - receive byte FIFO with sticky overrun flag
//
// Purpose: buffers bytes from the RX shift core until the driver reads them.
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   push, push_data byte arriving from the RX core
//   pop             driver read of the data register
//   ovr_clr         driver read of the status register (clears overrun)
//   head            byte at the read pointer (valid when !empty)
//   empty           no bytes stored
//   overrun         sticky: a byte was dropped because the FIFO was full

module spart_rx_fifo #(
   parameter int RX_DEPTH = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       push,
   input  logic [7:0] push_data,
   input  logic       pop,
   input  logic       ovr_clr,
   output logic [7:0] head,
   output logic       empty,
   output logic       overrun
);

   localparam int PW = $clog2(RX_DEPTH);
   localparam int CW = PW + 1;

   logic [7:0]    mem [RX_DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic          full;
   logic          pop_ok;
   logic          push_ok;
   logic          ovr_evt;

   assign empty = (count == '0);
   assign full  = (count == CW'(RX_DEPTH));

   // A pop in the same cycle frees a slot, so a push into a full FIFO
   // is still accepted when the driver is reading at the same time.
   assign pop_ok  = pop & ~empty;
   assign push_ok = push & (~full | pop_ok);
   assign ovr_evt = push & ~push_ok;

   assign head = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr] <= push_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         overrun <= 1'b0;
      end else begin
         // Pointer width equals log2(depth), so increments wrap by themselves.
         if (push_ok) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (pop_ok) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         count <= count + CW'(push_ok) - CW'(pop_ok);
         // A new drop wins over a clear in the same cycle.
         if (ovr_evt) begin
            overrun <= 1'b1;
         end else if (ovr_clr) begin
            overrun <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/spart_bus_responder.sv
// rtl/spart_bus_responder.sv - SPART processor-side register responder
//
// Purpose: decodes iocs/iorw/ioaddr accesses, owns the databus, holds the
//          baud divisor, the TX holding register and the RX FIFO.
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   iocs, iorw, ioaddr  bus access: one access per clk with iocs=1, iorw=1 read
//   databus             bidirectional data, driven only during reads
//   rda, tbr            receive data available / transmit buffer ready
//   tx_data, tx_start   byte and one-cycle start pulse to the TX core
//   tx_busy             TX core is shifting
//   rx_data, rx_valid   byte and one-cycle strobe from the RX core
//   baud_div, baud_load divisor and one-cycle reload pulse to the baud generator

module spart_bus_responder
   import spart_pkg::*;
#(
   parameter int          RX_DEPTH    = 4,
   parameter logic [15:0] DEFAULT_DIV = 16'd325
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        iocs,
   input  logic        iorw,
   input  logic [1:0]  ioaddr,
   inout  wire  [7:0]  databus,
   output logic        rda,
   output logic        tbr,
   output logic [7:0]  tx_data,
   output logic        tx_start,
   input  logic        tx_busy,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic [15:0] baud_div,
   output logic        baud_load
);

   logic       rd_access;
   logic       wr_access;
   logic [7:0] rd_data;
   logic [7:0] fifo_head;
   logic       fifo_empty;
   logic       overrun;
   logic [7:0] hold;
   logic       hold_load;
   tx_state_e  state;
   tx_state_e  state_next;

   assign rd_access = iocs & iorw;
   assign wr_access = iocs & ~iorw;

   // ---------------- RX path ----------------
   spart_rx_fifo #(
      .RX_DEPTH (RX_DEPTH)
   ) u_rx_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (rx_valid),
      .push_data (rx_data),
      .pop       (rd_access && (ioaddr == ADDR_DATA)),
      .ovr_clr   (rd_access && (ioaddr == ADDR_STATUS)),
      .head      (fifo_head),
      .empty     (fifo_empty),
      .overrun   (overrun)
   );

   // The FIFO count is a register, so this follows a push/pop by one cycle.
   assign rda = ~fifo_empty;

   // ---------------- Read mux and bus driver ----------------
   always_comb begin
      rd_data = 8'h00;
      case (ioaddr)
         ADDR_DATA:   rd_data = fifo_empty ? 8'h00 : fifo_head;
         ADDR_STATUS: begin
            rd_data[STAT_RDA] = rda;
            rd_data[STAT_TBR] = tbr;
            rd_data[STAT_OVR] = overrun;
         end
         ADDR_DB_LO:  rd_data = baud_div[7:0];
         ADDR_DB_HI:  rd_data = baud_div[15:8];
         default:     rd_data = 8'h00;
      endcase
   end

   assign databus = rd_access ? rd_data : 8'hzz;

   // ---------------- TX holding register ----------------
   assign hold_load = wr_access && (ioaddr == ADDR_DATA) && (state == TX_EMPTY);

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= TX_EMPTY;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         TX_EMPTY: if (hold_load) state_next = TX_FULL;
         TX_FULL:  if (!tx_busy)  state_next = TX_EMPTY;
         default:  state_next = TX_EMPTY;
      endcase
   end

   always_comb begin
      tbr      = 1'b0;
      tx_start = 1'b0;
      case (state)
         TX_EMPTY: tbr      = 1'b1;
         TX_FULL:  tx_start = ~tx_busy;
         default:  tbr      = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hold <= 8'h00;
      end else if (hold_load) begin
         hold <= databus;
      end
   end

   assign tx_data = hold;

   // ---------------- Baud divisor ----------------
   // Only the high-byte write reloads, so the driver writes low then high
   // and the generator never sees a half-updated divisor.
   always_ff @(posedge clk) begin
      if (rst) begin
         baud_div  <= DEFAULT_DIV;
         baud_load <= 1'b0;
      end else begin
         baud_load <= wr_access && (ioaddr == ADDR_DB_HI);
         if (wr_access && (ioaddr == ADDR_DB_LO)) begin
            baud_div[7:0] <= databus;
         end
         if (wr_access && (ioaddr == ADDR_DB_HI)) begin
            baud_div[15:8] <= databus;
         end
      end
   end

endmodule

// File: tb/tb_spart_bus_responder.sv
// tb/tb_spart_bus_responder.sv - self-checking bench for spart_bus_responder

module tb_spart_bus_responder;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        iocs;
   logic        iorw;
   logic [1:0]  ioaddr;
   logic        tx_busy;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic [7:0]  drv;
   logic        drv_en;
   wire  [7:0]  databus;
   logic        rda;
   logic        tbr;
   logic [7:0]  tx_data;
   logic        tx_start;
   logic [15:0] baud_div;
   logic        baud_load;

   int vectors     = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   assign databus = drv_en ? drv : 8'hzz;

   spart_bus_responder #(
      .RX_DEPTH    (DEPTH),
      .DEFAULT_DIV (16'd325)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .iocs      (iocs),
      .iorw      (iorw),
      .ioaddr    (ioaddr),
      .databus   (databus),
      .rda       (rda),
      .tbr       (tbr),
      .tx_data   (tx_data),
      .tx_start  (tx_start),
      .tx_busy   (tx_busy),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .baud_div  (baud_div),
      .baud_load (baud_load)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- Behavioural model ----------------
   logic [7:0]  mq[$];
   logic        m_ovr;
   logic        m_full;
   logic [7:0]  m_hold;
   logic [15:0] m_div;
   logic        m_load;
   logic        m_evt;
   bit          live = 1'b0;

   function automatic logic [7:0] m_read(input logic [1:0] a);
      case (a)
         2'b00:   return (mq.size() != 0) ? mq[0] : 8'h00;
         2'b01:   return {5'b0, m_ovr, ~m_full, (mq.size() != 0)};
         2'b10:   return m_div[7:0];
         default: return m_div[15:8];
      endcase
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         mq.delete();
         m_ovr  = 1'b0;
         m_full = 1'b0;
         m_hold = 8'h00;
         m_div  = 16'd325;
         m_load = 1'b0;
         live   = 1'b1;
      end else begin
         m_evt = 1'b0;
         if (iocs && iorw && ioaddr == 2'b00 && mq.size() != 0) void'(mq.pop_front());
         if (rx_valid) begin
            if (mq.size() < DEPTH) mq.push_back(rx_data);
            else m_evt = 1'b1;
         end
         if (m_evt) m_ovr = 1'b1;
         else if (iocs && iorw && ioaddr == 2'b01) m_ovr = 1'b0;
         if (m_full) begin
            if (!tx_busy) m_full = 1'b0;
         end else if (iocs && !iorw && ioaddr == 2'b00) begin
            m_full = 1'b1;
            m_hold = databus;
         end
         m_load = iocs && !iorw && ioaddr == 2'b11;
         if (iocs && !iorw && ioaddr == 2'b10) m_div[7:0]  = databus;
         if (iocs && !iorw && ioaddr == 2'b11) m_div[15:8] = databus;
      end
   end

   always @(negedge clk) begin
      if (live) begin
         chk("rda",       32'(rda),       32'(mq.size() != 0));
         chk("tbr",       32'(tbr),       32'(!m_full));
         chk("tx_start",  32'(tx_start),  32'(m_full && !tx_busy));
         chk("tx_data",   32'(tx_data),   32'(m_hold));
         chk("baud_div",  32'(baud_div),  32'(m_div));
         chk("baud_load", 32'(baud_load), 32'(m_load));
         if (iocs && iorw) chk("bus_read", 32'(databus), 32'(m_read(ioaddr)));
      end
   end

   // ---------------- Stimulus helpers (start and end at posedge+1) ----------------
   task automatic cycle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic bus_write(input logic [1:0] a, input logic [7:0] v);
      iocs = 1'b1; iorw = 1'b0; ioaddr = a; drv = v; drv_en = 1'b1;
      cycle(1);
      iocs = 1'b0; drv_en = 1'b0;
   endtask

   task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
      iocs = 1'b1; iorw = 1'b1; ioaddr = a; drv_en = 1'b0;
      @(negedge clk);
      d = databus;
      cycle(1);
      iocs = 1'b0; iorw = 1'b0;
   endtask

   task automatic rx_push(input logic [7:0] b);
      rx_valid = 1'b1; rx_data = b;
      cycle(1);
      rx_valid = 1'b0;
   endtask

   logic [7:0] d;

   initial begin
      rst = 1'b1; iocs = 1'b0; iorw = 1'b0; ioaddr = 2'b00; tx_busy = 1'b0;
      rx_valid = 1'b0; rx_data = 8'h00; drv = 8'h00; drv_en = 1'b0;
      cycle(2);
      rst = 1'b0;

      // Reset state; bus released while idle (tb drive reads back unchanged)
      drv = 8'hA5; drv_en = 1'b1;
      @(negedge clk);
      chk("rst_baud_div", 32'(baud_div), 32'd325);
      chk("rst_tbr",      32'(tbr),      32'd1);
      chk("rst_rda",      32'(rda),      32'd0);
      chk("rst_tx_data",  32'(tx_data),  32'h00);
      chk("idle_release", 32'(databus),  32'hA5);
      cycle(1);
      drv_en = 1'b0;
      bus_read(2'b01, d); chk("rst_status", 32'(d), 32'h02);

      // Divisor: low byte gives no reload, high byte reloads next cycle
      bus_write(2'b10, 8'h45);
      @(negedge clk); chk("no_load_lo", 32'(baud_load), 32'd0);
      cycle(1);
      bus_write(2'b11, 8'h01);
      @(negedge clk);
      chk("load_hi",  32'(baud_load), 32'd1);
      chk("div_new",  32'(baud_div),  32'h0145);
      cycle(1);
      @(negedge clk); chk("load_once", 32'(baud_load), 32'd0);
      cycle(1);
      bus_read(2'b10, d); chk("rd_div_lo", 32'(d), 32'h45);
      bus_read(2'b11, d); chk("rd_div_hi", 32'(d), 32'h01);

      // Transmit while busy; second write ignored
      tx_busy = 1'b1;
      bus_write(2'b00, 8'hA5);
      @(negedge clk);
      chk("tx_tbr_full", 32'(tbr),      32'd0);
      chk("tx_no_start", 32'(tx_start), 32'd0);
      cycle(1);
      bus_write(2'b00, 8'h3C);
      cycle(2);
      tx_busy = 1'b0;
      @(negedge clk);
      chk("tx_start",  32'(tx_start), 32'd1);
      chk("tx_data",   32'(tx_data),  32'hA5);
      cycle(1);
      @(negedge clk);
      chk("tx_single", 32'(tx_start), 32'd0);
      chk("tx_tbr_back", 32'(tbr),    32'd1);
      cycle(1);
      // Minimum latency: start on the cycle right after the write
      bus_write(2'b00, 8'h5A);
      @(negedge clk);
      chk("tx_min_lat", 32'(tx_start), 32'd1);
      chk("tx_min_dat", 32'(tx_data),  32'h5A);
      cycle(2);

      // Receive order and empty read
      rx_push(8'h11); rx_push(8'h22); rx_push(8'h33);
      @(negedge clk); chk("rx_rda", 32'(rda), 32'd1);
      cycle(1);
      bus_read(2'b00, d); chk("rx_1", 32'(d), 32'h11);
      bus_read(2'b00, d); chk("rx_2", 32'(d), 32'h22);
      bus_read(2'b00, d); chk("rx_3", 32'(d), 32'h33);
      bus_read(2'b00, d); chk("rx_empty", 32'(d), 32'h00);
      @(negedge clk); chk("rx_rda_clr", 32'(rda), 32'd0);
      cycle(1);

      // Overrun: five pushes into four entries
      for (int i = 0; i < 5; i++) rx_push(8'(8'h41 + i));
      bus_read(2'b01, d); chk("ovr_status", 32'(d), 32'h07);
      bus_read(2'b01, d); chk("ovr_cleared", 32'(d), 32'h03);
      for (int i = 0; i < 4; i++) begin
         bus_read(2'b00, d); chk("ovr_data", 32'(d), 32'(8'h41 + i));
      end
      bus_read(2'b00, d); chk("ovr_drained", 32'(d), 32'h00);

      // Simultaneous push and pop while full
      for (int i = 0; i < 4; i++) rx_push(8'(8'h51 + i));
      rx_valid = 1'b1; rx_data = 8'h55;
      bus_read(2'b00, d);
      rx_valid = 1'b0;
      chk("sim_head", 32'(d), 32'h51);
      bus_read(2'b01, d); chk("sim_no_ovr", 32'(d), 32'h03);
      for (int i = 0; i < 4; i++) begin
         bus_read(2'b00, d); chk("sim_data", 32'(d), 32'(8'h52 + i));
      end

      // Overrun in the same cycle as a status read stays set
      for (int i = 0; i < 4; i++) rx_push(8'(8'h61 + i));
      rx_valid = 1'b1; rx_data = 8'h65;
      bus_read(2'b01, d);
      rx_valid = 1'b0;
      chk("ovr_race_rd", 32'(d), 32'h03);
      bus_read(2'b01, d); chk("ovr_race_kept", 32'(d), 32'h07);
      bus_read(2'b01, d); chk("ovr_race_clr",  32'(d), 32'h03);
      for (int i = 0; i < 4; i++) begin
         bus_read(2'b00, d); chk("race_data", 32'(d), 32'(8'h61 + i));
      end

      // Reset mid-transfer discards FIFO, holding byte and divisor
      rx_push(8'h71); rx_push(8'h72);
      tx_busy = 1'b1;
      bus_write(2'b00, 8'h99);
      bus_write(2'b11, 8'h07);
      rst = 1'b1;
      cycle(1);
      rst = 1'b0;
      @(negedge clk);
      chk("mid_rst_rda", 32'(rda),      32'd0);
      chk("mid_rst_tbr", 32'(tbr),      32'd1);
      chk("mid_rst_div", 32'(baud_div), 32'd325);
      cycle(1);
      tx_busy = 1'b0;
      cycle(3);
      bus_read(2'b00, d); chk("mid_rst_fifo", 32'(d), 32'h00);
      cycle(2);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/spart_bus_responder.md
Name: spart_bus_responder

Overview:
- Register-mapped responder on the SPART processor-side bus (iocs/iorw/ioaddr/databus). The driver is the initiator on this bus.
- Decodes bus accesses and owns the bidirectional databus.
- Holds the baud divisor, the TX holding register and a small RX FIFO.
- Hands bytes to the TX shift core and accepts bytes from the RX shift core. Sits inside spart, between the bus pins and the serial cores.

Parameters:
- RX_DEPTH, 4, RX FIFO entries (power of two, 2..16).
- DEFAULT_DIV, 16'd325, baud divisor loaded at reset (100 MHz, 16x oversample, 19200 baud).

Ports:
- clk  input  1  100 MHz system clock.
- rst  input  1  synchronous, active-high reset.
- iocs  input  1  chip select; each clk with iocs=1 is exactly one access.
- iorw  input  1  1 = read, 0 = write.
- ioaddr  input  2  register select.
- databus  inout  8  bidirectional data; driven by this block only when iocs=1 and iorw=1, else 8'hzz.
- rda  output  1  receive data available (RX FIFO not empty).
- tbr  output  1  transmit buffer ready (holding register empty).
- tx_data  output  8  byte to TX core.
- tx_start  output  1  one-cycle pulse; TX core latches tx_data.
- tx_busy  input  1  TX core shifting.
- rx_data  input  8  byte from RX core.
- rx_valid  input  1  one-cycle pulse; rx_data valid.
- baud_div  output  16  current divisor.
- baud_load  output  1  one-cycle pulse; baud generator reloads.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst. All state updates on the rising clk edge.
- Reset values:
  - rda=0, tbr=1, tx_start=0, tx_data=8'h00, baud_load=0.
  - baud_div=DEFAULT_DIV.
  - FIFO empty, overrun=0, databus released.
  - Reset mid-transfer discards the FIFO contents and the holding byte.
- Address map:
  - 00 read: RX data; pops the FIFO head.
  - 00 write: TX holding register.
  - 01 read: status {5'b0, overrun, tbr, rda}.
  - 01 write: ignored.
  - 10 read/write: divisor low byte.
  - 11 read/write: divisor high byte.
- Read data is combinational from the current state (same cycle as iocs). Pop, status clear and register writes take effect at the end of that cycle.
- RX FIFO:
  - Push on rx_valid.
  - rda = count!=0, registered from the count, so it updates the cycle after a push or pop.
  - Read of addr 00 when empty returns 8'h00; pointers unchanged.
  - Push when full: incoming byte dropped, overrun set (sticky).
  - Same-cycle push and pop: both occur, count unchanged. If full, the pop frees a slot and the push is accepted (no overrun).
  - Status read returns the current overrun value, then clears it. If an overrun occurs in the same cycle as the status read, overrun stays set.
  - Pointers wrap modulo RX_DEPTH; count is width clog2(RX_DEPTH)+1.
- TX path, holding FSM with states EMPTY and FULL:
  - EMPTY: a write to 00 latches the byte -> FULL; tbr=0 from the next cycle.
  - FULL and tx_busy=0: drive tx_data=hold, pulse tx_start for one cycle -> EMPTY; tbr=1 the following cycle.
  - Write to 00 while FULL: ignored, no state change.
  - Minimum latency from write to tx_start is 1 cycle.
- Divisor:
  - A write to 10 updates the low byte only; no baud_load.
  - A write to 11 updates the high byte and pulses baud_load the next cycle with the full new baud_div stable.
- Undefined ioaddr/iorw combinations: none; all 8 are covered above.

Decomposition:
- Shared package spart_pkg holds:
  - Address constants ADDR_DATA=2'b00, ADDR_STATUS=2'b01, ADDR_DB_LO=2'b10, ADDR_DB_HI=2'b11.
  - Status bit indices.
  - The TX holding state enum.
- One natural sub-module: spart_rx_fifo, with the push/pop/count/full/empty/overrun logic parameterised by RX_DEPTH.

Test Plan:
- Reset: assert rst 2 cycles -> baud_div=16'd325, tbr=1, rda=0, databus=zz, status read = 8'h02.
- Divisor: write 10=8'h45, then 11=8'h01 -> baud_div=16'h0145; baud_load high exactly 1 cycle after the 11 write; no pulse after the 10 write.
- Transmit: tx_busy=1, write 00=8'hA5 -> tbr=0, no tx_start. Second write 8'h3C is ignored. Release tx_busy -> one tx_start with tx_data=8'hA5, then tbr=1.
- Receive order: push 8'h11, 8'h22, 8'h33 -> rda=1. Three reads of 00 return 11, 22, 33; a fourth read returns 8'h00 and rda=0.
- Overrun: push 5 bytes with RX_DEPTH=4:
  - Status = 8'h07 (overrun, tbr, rda set).
  - Next status read = 8'h03 (overrun cleared).
  - Reads return the first 4 bytes only.
- Simultaneous: FIFO full, rx_valid in the same cycle as a read of 00 -> head returned, new byte stored last, overrun stays 0.
